load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the decode/ALU stage.
- Accepts load and store operations. The effective address comes from the ALU result, store data from rs2, and rd from decode.
- Runs one transaction at a time over a req/gnt/rvalid data-memory handshake, formats byte/half/word data, and returns load results to the register-file writeback path.
- Asserts busy so fetch/decode stall while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ+WAIT before the access is aborted with err; legal range 2..255.
- ADDR_W, 32: address width of addr and mem_addr.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  execute stage presents an operation
- op_ready  out  1  unit idle, will accept op this cycle
- is_load  in  1  operation is a load
- is_store  in  1  operation is a store
- funct3  in  3  RV32I width/sign field
- addr  in  ADDR_W  effective address (rs1 + imm)
- store_data  in  32  rs2 value
- rd  in  5  load destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data valid / write complete
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle load-result pulse
- wb_rd  out  5  destination register for wb_data
- wb_data  out  32  extended load result
- busy  out  1  access outstanding, pipeline must stall
- err  out  1  one-cycle error pulse

Behaviour:
- Reset, while asserted:
  - state=IDLE, timeout counter=0.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, err, busy all 0.
  - op_ready forced 0.
  - Reset mid-transaction: mem_req low from the next edge; any later mem_rvalid is ignored in IDLE.
- op_ready = (state==IDLE) && !reset. busy = state!=IDLE.
- Accept happens on an edge with op_valid && op_ready. Operand fields are captured in registers; inputs may change afterwards.
- Illegal ops are consumed with no memory traffic, err pulses the next cycle, and the unit stays IDLE. Illegal means:
  - is_load==is_store;
  - load funct3 of 011, 110 or 111;
  - store funct3[2]==1.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- States:
  - IDLE -> REQ on legal accept.
  - REQ: mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt. On mem_gnt: go to WAIT, or straight back to IDLE if mem_rvalid is also high that cycle (zero-wait memory).
  - WAIT: mem_req=0. On mem_rvalid, go to IDLE and complete.
  - Timeout: the counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES without completion, the unit drops mem_req, pulses err, returns to IDLE and produces no wb. A late mem_rvalid is then ignored.
- Store formatting:
  - SB: mem_be=0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: mem_be=0011<<{addr[1],1'b0}, wdata={2{sd[15:0]}}.
  - SW: mem_be=1111, wdata=sd.
  - mem_we=1.
- Load formatting:
  - mem_be is as for stores, mem_we=0.
  - The rdata word is shifted right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Completion:
  - Loads: wb_valid pulses exactly one cycle, on the edge after mem_rvalid, with wb_rd and wb_data. rd==0 still pulses; the register file discards it.
  - Stores complete on mem_rvalid with no wb pulse.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. Handling is set by MISALIGN_TRAP_EN (below).
- Minimum occupancy:
  - accept at edge N; mem_req high in cycle N+1;
  - gnt+rvalid in N+1 gives wb_valid in N+2 and op_ready in N+2.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A misaligned access is consumed without a memory request.
  - err pulses the cycle after accept; there is no wb.
- Not defined:
  - Offending low address bits are cleared: bit 0 for halfword, bits 1:0 for word.
  - The access proceeds naturally aligned and err never fires for misalignment.

Test Plan:
- SW addr=0x104, sd=0xDEADBEEF, gnt+rvalid same cycle -> mem_addr=0x104, be=1111, we=1, wdata=0xDEADBEEF, no wb_valid, op_ready back after 2 cycles.
- LB addr=0x103, rdata=0x80FF_0000, rd=5, gnt in cycle 1, rvalid in cycle 3 -> be=1000, wb_valid one pulse, wb_rd=5, wb_data=0xFFFFFF80. Repeat as LBU -> wb_data=0x00000080.
- SH addr=0x202, sd=0x0000ABCD -> be=1100, wdata=0xABCDABCD; mem_req held with stable fields for 4 cycles before gnt.
- Load with mem_gnt never asserted, TIMEOUT_CYCLES=16 -> err pulses on cycle 16 after accept, mem_req low, no wb; later rvalid ignored.
- LW addr=0x06: with MISALIGN_TRAP_EN -> no mem_req, err next cycle; without it -> mem_addr=0x04, be=1111.
- Reset asserted while in WAIT; rvalid arrives after reset releases -> mem_req=0, busy=0, no wb_valid. Also is_load=is_store=1 -> err pulse, no mem_req.

Source files
------------

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Memory stage behind decode/ALU. Takes one load or store at a time, runs it
//   over a req/gnt/rvalid data-memory handshake, formats byte/half/word data
//   and hands load results to the register-file writeback path.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned accesses are dropped with an err pulse, no memory traffic
//     undefined : offending low address bits are cleared and the access proceeds
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   op_valid / op_ready        operation handshake from execute (ready = idle)
//   is_load, is_store, funct3  operation kind and RV32I width/sign field
//   addr, store_data, rd       effective address, rs2 value, load destination
//   mem_req/we/addr/be/wdata   data-memory request (word-aligned address)
//   mem_gnt/rvalid/rdata       data-memory grant, response and read word
//   wb_valid/wb_rd/wb_data     one-cycle load writeback
//   busy                       access outstanding, pipeline must stall
//   err                        one-cycle error pulse (illegal op, timeout, trap)
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [4:0]          rd_q, rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                err_q, err_d;

  logic                illegal;
  logic                trap;
  logic [1:0]          off_new;
  logic [3:0]          be_new;
  logic [31:0]         wdata_new;
  logic [31:0]         shifted;
  logic [31:0]         ld_data;
  logic                complete;

  // Decode of the presented operation: legality, natural alignment of the
  // byte offset, byte enables and lane-replicated write data.
  always_comb begin
    illegal = (is_load == is_store)
            || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            || (is_store && funct3[2]);
    off_new = addr[1:0];
    if (funct3[1:0] == 2'b01) off_new[0] = 1'b0;
    if (funct3[1:0] == 2'b10) off_new = 2'b00;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << off_new;
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << off_new;
        wdata_new = {2{store_data[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = store_data;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    trap = (funct3[1:0] == 2'b01 && addr[0]) ||
           (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
  end

  // Read word alignment and sign/zero extension using the captured offset.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Next-state logic. Completion takes priority over timeout on the same edge;
  // a zero-wait memory (gnt and rvalid together in REQ) skips WAIT entirely.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (op_valid && op_ready) begin
          if (illegal || trap) begin
            err_d = 1'b1;
          end else begin
            state_d  = REQ;
            we_d     = is_store;
            be_d     = be_new;
            addr_d   = addr[ADDR_W-1:2];
            wdata_d  = wdata_new;
            funct3_d = funct3;
            off_d    = off_new;
            rd_d     = rd;
          end
        end
      end
      REQ, WAIT: begin
        complete = (state_q == REQ) ? (mem_gnt && mem_rvalid) : mem_rvalid;
        if (complete) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
          end
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == REQ && mem_gnt) state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      we_q       <= 1'b0;
      be_q       <= 4'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b0;
      off_q      <= 2'b0;
      rd_q       <= 5'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'b0;
      wb_data_q  <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign op_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit: a table of single zero-wait accesses
//   (formatting, extension, illegal ops, misalignment) followed by hand-written
//   multi-cycle sequences (delayed rvalid, stalled grant, timeout, reset in WAIT).
//   Expected misalignment behaviour follows the MISALIGN_TRAP_EN macro.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid;
  logic              op_ready;
  logic              is_load;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic [4:0]        rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              busy;
  logic              err;

  load_store_unit #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  r;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   checks = 0;
  int   errors = 0;

  // One comparison: count it, report a failure with actual and required values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the unit for the next edge.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [4:0] r);
    op_valid   = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd         = r;
  endtask

  // Withdraw the operation and scramble the operand fields so that only
  // captured values can reach the memory port.
  task automatic clearStimulus();
    op_valid   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b111;
    addr       = 32'hFFFF_FFFF;
    store_data = 32'h5555_AAAA;
    rd         = 5'h1F;
  endtask

  // Byte load at 0x103: grant in the first REQ cycle, rvalid two cycles later.
  task automatic runByteLoadSeq(input logic [2:0] f3, input logic [31:0] exp_data,
                                input string tag);
    applyStimulus(1'b1, 1'b0, f3, 32'h103, 32'h0, 5'd5);
    tick();
    clearStimulus();
    checkOutput({tag, " req"}, mem_req, 1'b1);
    checkOutput({tag, " addr"}, mem_addr, 32'h100);
    checkOutput({tag, " be"}, mem_be, 4'b1000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput({tag, " req after gnt"}, mem_req, 1'b0);
    checkOutput({tag, " busy in wait"}, busy, 1'b1);
    tick();
    checkOutput({tag, " no early wb"}, wb_valid, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0BAD_0BAD;
    checkOutput({tag, " wb_valid"}, wb_valid, 1'b1);
    checkOutput({tag, " wb_rd"}, wb_rd, 5'd5);
    checkOutput({tag, " wb_data"}, wb_data, exp_data);
    tick();
    checkOutput({tag, " wb pulse end"}, wb_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ld st f3 addr sd rd rdata | err exp_addr be wdata wb
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, 32'h0,
                     1'b0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 5'd0, 32'h0,
                     1'b0, 32'h100, 4'b0010, 32'h78787878, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 32'h0,
                     1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h003, 32'h000000AA, 5'd0, 32'h0,
                     1'b0, 32'h000, 4'b1000, 32'hAAAAAAAA, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 32'h11223344,
                     1'b0, 32'h100, 4'b1111, 32'h0, 32'h11223344});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd3, 32'h80010000,
                     1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd4, 32'h80010000,
                     1'b0, 32'h100, 4'b1100, 32'h0, 32'h00008001});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 5'd8, 32'h12347FFF,
                     1'b0, 32'h100, 4'b0011, 32'h0, 32'h00007FFF});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 5'd9, 32'h00007F00,
                     1'b0, 32'h100, 4'b0010, 32'h0, 32'h0000007F});
    vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd10, 32'h00AB0000,
                     1'b0, 32'h100, 4'b0100, 32'h0, 32'h000000AB});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd0, 32'h000000F0,
                     1'b0, 32'h100, 4'b0001, 32'h0, 32'hFFFFFFF0});
`ifdef MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 5'd11, 32'hCAFEF00D,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h203, 32'h00001234, 5'd0, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd12, 32'h00009000,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
`else
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 5'd11, 32'hCAFEF00D,
                     1'b0, 32'h004, 4'b1111, 32'h0, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h203, 32'h00001234, 5'd0, 32'h0,
                     1'b0, 32'h200, 4'b1100, 32'h12341234, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd12, 32'h00009000,
                     1'b0, 32'h100, 4'b0011, 32'h0, 32'hFFFF9000});
`endif
    vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b110, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b111, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd1, 32'h0,
                     1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});

    // Reset state
    reset      = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    clearStimulus();
    tick();
    tick();
    checkOutput("reset mem_req", mem_req, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset op_ready", op_ready, 1'b0);
    checkOutput("reset wb_valid", wb_valid, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset mem_be", mem_be, 4'b0000);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("op_ready after reset", op_ready, 1'b1);

    // Table of zero-wait single accesses
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      checkOutput($sformatf("v%0d op_ready", i), op_ready, 1'b1);
      applyStimulus(v.ld, v.st, v.f3, v.a, v.sd, v.r);
      tick();
      clearStimulus();
      if (v.exp_err) begin
        checkOutput($sformatf("v%0d err", i), err, 1'b1);
        checkOutput($sformatf("v%0d no req", i), mem_req, 1'b0);
        checkOutput($sformatf("v%0d not busy", i), busy, 1'b0);
        checkOutput($sformatf("v%0d no wb", i), wb_valid, 1'b0);
        tick();
        checkOutput($sformatf("v%0d err pulse end", i), err, 1'b0);
      end else begin
        checkOutput($sformatf("v%0d req", i), mem_req, 1'b1);
        checkOutput($sformatf("v%0d busy", i), busy, 1'b1);
        checkOutput($sformatf("v%0d op_ready low", i), op_ready, 1'b0);
        checkOutput($sformatf("v%0d addr", i), mem_addr, v.exp_addr);
        checkOutput($sformatf("v%0d be", i), mem_be, v.exp_be);
        checkOutput($sformatf("v%0d we", i), mem_we, v.st);
        if (v.st) checkOutput($sformatf("v%0d wdata", i), mem_wdata, v.exp_wdata);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BAD_0BAD;
        checkOutput($sformatf("v%0d wb_valid", i), wb_valid, v.ld);
        if (v.ld) begin
          checkOutput($sformatf("v%0d wb_rd", i), wb_rd, v.r);
          checkOutput($sformatf("v%0d wb_data", i), wb_data, v.exp_wb);
        end
        checkOutput($sformatf("v%0d op_ready back", i), op_ready, 1'b1);
        checkOutput($sformatf("v%0d req dropped", i), mem_req, 1'b0);
        checkOutput($sformatf("v%0d no err", i), err, 1'b0);
        tick();
        checkOutput($sformatf("v%0d wb pulse end", i), wb_valid, 1'b0);
      end
    end

    // Delayed rvalid, signed and unsigned byte
    runByteLoadSeq(3'b000, 32'hFFFFFF80, "lb103");
    runByteLoadSeq(3'b100, 32'h00000080, "lbu103");

    // Halfword store stalled for four cycles before grant
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0);
    tick();
    clearStimulus();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("sh stall%0d req", c), mem_req, 1'b1);
      checkOutput($sformatf("sh stall%0d addr", c), mem_addr, 32'h200);
      checkOutput($sformatf("sh stall%0d be", c), mem_be, 4'b1100);
      checkOutput($sformatf("sh stall%0d wdata", c), mem_wdata, 32'hABCDABCD);
      checkOutput($sformatf("sh stall%0d we", c), mem_we, 1'b1);
      if (c < 3) tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("sh wait req low", mem_req, 1'b0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("sh no wb", wb_valid, 1'b0);
    checkOutput("sh op_ready back", op_ready, 1'b1);

    // Timeout with the grant never arriving
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd6);
    tick();
    clearStimulus();
    for (int c = 1; c < TIMEOUT_CYCLES; c++) begin
      tick();
      checkOutput($sformatf("timeout c%0d no err", c), err, 1'b0);
      checkOutput($sformatf("timeout c%0d req", c), mem_req, 1'b1);
    end
    tick();
    checkOutput("timeout err", err, 1'b1);
    checkOutput("timeout req low", mem_req, 1'b0);
    checkOutput("timeout not busy", busy, 1'b0);
    checkOutput("timeout no wb", wb_valid, 1'b0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("timeout err pulse end", err, 1'b0);
    tick();
    checkOutput("late rvalid no wb", wb_valid, 1'b0);
    checkOutput("late rvalid idle", busy, 1'b0);

    // Reset while waiting for rvalid; the response arrives after release
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd2);
    tick();
    clearStimulus();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("rst wait busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("rst mem_req", mem_req, 1'b0);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst op_ready", op_ready, 1'b0);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFEEDFACE;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("rst late rvalid no wb", wb_valid, 1'b0);
    checkOutput("rst late rvalid busy", busy, 1'b0);
    checkOutput("rst late rvalid req", mem_req, 1'b0);
    checkOutput("rst op_ready back", op_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
